// File: rtl/mpu_pkg.sv
// Shared types and default sizing for the MPU matrix register file.
package mpu_pkg;

  localparam int unsigned DEF_FP       = 32;
  localparam int unsigned DEF_M_MAX    = 4;
  localparam int unsigned DEF_N_MAX    = 4;
  localparam int unsigned DEF_NUM_REGS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } regfile_state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_SIZE  = 2'd1,
    ERR_EMPTY = 2'd2,
    ERR_BUSY  = 2'd3
  } regfile_err_e;

endpackage

// File: rtl/mpu_matrix_index_gen.sv
// Row/column index generator for row-major or column-major matrix walks.
// i_clr zeroes both indices; i_en advances by one element; o_last flags (m-1, n-1).
module mpu_matrix_index_gen #(
  parameter int unsigned MW = 3,
  parameter int unsigned NW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_transpose,
  input  logic [MW-1:0] i_m,
  input  logic [NW-1:0] i_n,
  output logic [MW-1:0] o_i,
  output logic [NW-1:0] o_j,
  output logic          o_last
);

  logic [MW-1:0] r_i;
  logic [NW-1:0] r_j;
  logic          w_i_end;
  logic          w_j_end;

  assign w_i_end = (r_i == i_m - MW'(1));
  assign w_j_end = (r_j == i_n - NW'(1));
  assign o_i     = r_i;
  assign o_j     = r_j;
  assign o_last  = w_i_end & w_j_end;

  // Advance the fast index and carry into the slow one on wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_clr) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_en) begin
      if (i_transpose) begin
        if (w_i_end) begin
          r_i <= '0;
          r_j <= r_j + NW'(1);
        end else begin
          r_i <= r_i + MW'(1);
        end
      end else begin
        if (w_j_end) begin
          r_j <= '0;
          r_i <= r_i + MW'(1);
        end else begin
          r_j <= r_j + NW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mpu_matrix_regfile.sv
// Multi-register matrix file: row-major load/store streams with valid/ready.
// Optional column-major readout is enabled by defining MPU_REGFILE_TRANSPOSE_EN.
module mpu_matrix_regfile
  import mpu_pkg::*;
#(
  parameter int unsigned FP       = DEF_FP,
  parameter int unsigned M_MAX    = DEF_M_MAX,
  parameter int unsigned N_MAX    = DEF_N_MAX,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  localparam int unsigned AW = $clog2(NUM_REGS),
  localparam int unsigned MW = $clog2(M_MAX + 1),
  localparam int unsigned NW = $clog2(N_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start_in,
  input  logic [AW-1:0] load_addr_in,
  input  logic [MW-1:0] load_m_in,
  input  logic [NW-1:0] load_n_in,
  input  logic          load_valid_in,
  input  logic [FP-1:0] load_data_in,
  output logic          load_ready_out,
  input  logic          store_start_in,
  input  logic [AW-1:0] store_addr_in,
  input  logic          store_transpose_in,
  output logic          store_valid_out,
  output logic [FP-1:0] store_data_out,
  output logic          store_last_out,
  input  logic          store_ready_in,
  output logic [MW-1:0] store_m_out,
  output logic [NW-1:0] store_n_out,
  output logic          busy_out,
  output logic          err_out,
  output logic [1:0]    err_code_out
);

  localparam int unsigned IW = $clog2(M_MAX);
  localparam int unsigned JW = $clog2(N_MAX);

  regfile_state_e r_state, w_state_d;
  regfile_err_e   r_err_code, w_code_d;
  logic           r_err, w_err_d;

  logic [FP-1:0]       r_mem [NUM_REGS][M_MAX][N_MAX];
  logic [NUM_REGS-1:0] r_valid;
  logic [MW-1:0]       r_m_tab [NUM_REGS];
  logic [NW-1:0]       r_n_tab [NUM_REGS];

  logic [AW-1:0] r_laddr, r_saddr;
  logic [MW-1:0] r_lm, r_sm;
  logic [NW-1:0] r_ln, r_sn;

  logic          w_size_ok, w_load_acc, w_store_acc, w_lwr, w_sadv, w_sv;
  logic          w_stranspose;
  logic [MW-1:0] w_li, w_si;
  logic [NW-1:0] w_lj, w_sj;
  logic          w_llast, w_slast;

`ifdef MPU_REGFILE_TRANSPOSE_EN
  logic r_stranspose;

  // Readout order is frozen at store start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stranspose <= 1'b0;
    end else if (w_store_acc) begin
      r_stranspose <= store_transpose_in;
    end
  end

  assign w_stranspose = r_stranspose;
`else
  logic w_unused_transpose;
  assign w_unused_transpose = store_transpose_in;
  assign w_stranspose       = 1'b0;
`endif

  assign w_size_ok = (load_m_in != '0) && (load_m_in <= MW'(M_MAX)) &&
                     (load_n_in != '0) && (load_n_in <= NW'(N_MAX));
  assign w_sv      = (r_state == STORE);
  assign w_lwr     = (r_state == LOAD) & load_valid_in;
  assign w_sadv    = w_sv & store_ready_in;

  mpu_matrix_index_gen #(.MW(MW), .NW(NW)) u_load_idx (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_load_acc),
    .i_en        (w_lwr),
    .i_transpose (1'b0),
    .i_m         (r_lm),
    .i_n         (r_ln),
    .o_i         (w_li),
    .o_j         (w_lj),
    .o_last      (w_llast)
  );

  mpu_matrix_index_gen #(.MW(MW), .NW(NW)) u_store_idx (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_store_acc),
    .i_en        (w_sadv),
    .i_transpose (w_stranspose),
    .i_m         (r_sm),
    .i_n         (r_sn),
    .o_i         (w_si),
    .o_j         (w_sj),
    .o_last      (w_slast)
  );

  // Start arbitration, error reporting and state transitions.
  always_comb begin
    w_state_d   = r_state;
    w_err_d     = 1'b0;
    w_code_d    = ERR_NONE;
    w_load_acc  = 1'b0;
    w_store_acc = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (load_start_in) begin
          if (w_size_ok) begin
            w_load_acc = 1'b1;
            w_state_d  = LOAD;
            if (store_start_in) begin
              // Load wins; the concurrent store is dropped.
              w_err_d  = 1'b1;
              w_code_d = ERR_BUSY;
            end
          end else begin
            w_err_d  = 1'b1;
            w_code_d = ERR_SIZE;
          end
        end else if (store_start_in) begin
          if (r_valid[store_addr_in]) begin
            w_store_acc = 1'b1;
            w_state_d   = STORE;
          end else begin
            w_err_d  = 1'b1;
            w_code_d = ERR_EMPTY;
          end
        end
      end
      LOAD: begin
        if (load_start_in || store_start_in) begin
          w_err_d  = 1'b1;
          w_code_d = ERR_BUSY;
        end
        if (w_lwr && w_llast) begin
          w_state_d = IDLE;
        end
      end
      STORE: begin
        if (load_start_in || store_start_in) begin
          w_err_d  = 1'b1;
          w_code_d = ERR_BUSY;
        end
        if (w_sadv && w_slast) begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // State, error pulse, transfer context and per-register tags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_valid    <= '0;
      r_laddr    <= '0;
      r_lm       <= '0;
      r_ln       <= '0;
      r_saddr    <= '0;
      r_sm       <= '0;
      r_sn       <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        r_m_tab[k] <= '0;
        r_n_tab[k] <= '0;
      end
    end else begin
      r_state    <= w_state_d;
      r_err      <= w_err_d;
      r_err_code <= w_code_d;
      if (w_load_acc) begin
        r_laddr                <= load_addr_in;
        r_lm                   <= load_m_in;
        r_ln                   <= load_n_in;
        // Invalidate up front so an interrupted load leaves nothing readable.
        r_valid[load_addr_in]  <= 1'b0;
      end
      if (w_lwr && w_llast) begin
        r_valid[r_laddr] <= 1'b1;
        r_m_tab[r_laddr] <= r_lm;
        r_n_tab[r_laddr] <= r_ln;
      end
      if (w_store_acc) begin
        r_saddr <= store_addr_in;
        r_sm    <= r_m_tab[store_addr_in];
        r_sn    <= r_n_tab[store_addr_in];
      end
    end
  end

  // Element storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_lwr) begin
      r_mem[r_laddr][w_li[IW-1:0]][w_lj[JW-1:0]] <= load_data_in;
    end
  end

  assign load_ready_out  = (r_state == LOAD);
  assign busy_out        = (r_state != IDLE);
  assign store_valid_out = w_sv;
  assign store_data_out  = w_sv ? r_mem[r_saddr][w_si[IW-1:0]][w_sj[JW-1:0]] : '0;
  assign store_last_out  = w_sv & w_slast;
  assign store_m_out     = w_sv ? (w_stranspose ? MW'(r_sn) : r_sm) : '0;
  assign store_n_out     = w_sv ? (w_stranspose ? NW'(r_sm) : r_sn) : '0;
  assign err_out         = r_err;
  assign err_code_out    = r_err_code;

endmodule

// File: doc/mpu_matrix_regfile.md
Name: mpu_matrix_regfile

Overview:
- Parametrised multi-register matrix file for the MPU. Holds NUM_REGS matrices of up to M_MAX x N_MAX FP elements, each with its own size and valid tag.
- Loads and stores whole matrices as row-major element streams with valid/ready handshakes. Row and column indices are generated internally.
- Flags size and address errors and emits a last-element marker on store.
- Sits between the memory-side load/store sequencer and the MPU compute array.

Parameters:
- FP, 32, element width in bits
- M_MAX, 4, maximum rows per matrix
- N_MAX, 4, maximum columns per matrix
- NUM_REGS, 8, number of matrix registers
- Derived (localparam, not overridable):
  - AW = $clog2(NUM_REGS)
  - MW = $clog2(M_MAX+1)
  - NW = $clog2(N_MAX+1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- load_start_in  in  1  request to begin a matrix load (one-cycle pulse)
- load_addr_in  in  AW  destination register
- load_m_in  in  MW  rows of the incoming matrix
- load_n_in  in  NW  columns of the incoming matrix
- load_valid_in  in  1  load element valid
- load_data_in  in  FP  load element
- load_ready_out  out  1  block accepts the load element
- store_start_in  in  1  request to begin a matrix store (one-cycle pulse)
- store_addr_in  in  AW  source register
- store_transpose_in  in  1  column-major readout (used only when TRANSPOSE_EN is defined)
- store_valid_out  out  FP-independent, 1  store element valid
- store_data_out  out  FP  store element
- store_last_out  out  1  final element of the matrix
- store_ready_in  in  1  consumer accepts the store element
- store_m_out  out  MW  rows of the matrix being stored
- store_n_out  out  NW  columns of the matrix being stored
- busy_out  out  1  FSM not in IDLE
- err_out  out  1  one-cycle pulse on a rejected start
- err_code_out  out  2  0 none, 1 bad size, 2 empty register, 3 start while busy

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; all valid tags cleared; size tables cleared.
  - All outputs 0, including load_ready_out, store_valid_out, store_last_out, err_out, err_code_out and busy_out.
  - Element storage is not reset.
- FSM states: IDLE, LOAD, STORE.
- IDLE, load start:
  - load_start_in with load_m_in in 1..M_MAX and load_n_in in 1..N_MAX: latch addr/m/n, zero i/j, go to LOAD.
  - Otherwise: err_out=1, err_code 1, stay in IDLE.
- IDLE, store start:
  - store_start_in to a valid register: latch addr and sizes, zero i/j, go to STORE.
  - Store to an unwritten register: err code 2, stay in IDLE.
- Simultaneous load and store start in IDLE: load wins; the store is dropped with err code 3.
- Any start while busy: err code 3; no state change.
- LOAD:
  - load_ready_out=1. Each cycle with load_valid_in & load_ready_out, write element to [addr][i][j].
  - Advance j; on j==n-1, wrap j to 0 and increment i.
  - On the final element (i==m-1, j==n-1): commit m/n, set the valid tag, return to IDLE.
  - load_ready_out drops the cycle after the final accept.
  - The register's valid tag is cleared on load start, so a partial load leaves the register invalid.
- STORE:
  - Output is registered. First store_valid_out appears 1 cycle after the start is accepted.
  - store_data_out, store_last_out and indices hold while store_valid_out & !store_ready_in.
  - On each handshake, present the next element in the following cycle. Full throughput is 1 element/cycle with ready held high.
  - store_last_out is asserted with the final element. Its handshake returns the FSM to IDLE and deasserts store_valid_out.
  - store_m_out/store_n_out are valid for the whole STORE state.
- 1x1 matrix: a single element; store_last_out is set on the first beat.
- Reset mid-LOAD: the register stays invalid. Reset mid-STORE: the output stream is truncated and store_valid_out goes to 0 immediately.

Optional Feature:
- Macro MPU_REGFILE_TRANSPOSE_EN.
- Defined: store_transpose_in is sampled at store start.
  - When set, readout is column-major: i advances fastest.
  - store_m_out/store_n_out report the swapped sizes (n, m).
  - store_last_out still marks the final element.
- Undefined: store_transpose_in is ignored and readout is always row-major.

Decomposition:
- Shared package mpu_pkg holds:
  - typedef regfile_state_e {IDLE, LOAD, STORE}
  - typedef regfile_err_e (2-bit codes)
  - default constants for M_MAX, N_MAX, NUM_REGS
- Sub-module mpu_matrix_index_gen: i/j counter with enable, wrap, transpose select and last flag. It is instantiated once each for load and store.

Test Plan:
- Load 2x3 into reg 5, data 1..6, valid every cycle: 6 accepts with ready=1, then ready drops and busy=0. Store reg 5 with ready high: outputs 1..6 on consecutive cycles, last on 6, m=2, n=3.
- Store with store_ready_in toggling 1,0,0,1,...: each element holds stable while ready=0; no duplicates or drops; total beats = m*n.
- load_m_in=0, then load_n_in=N_MAX+1: err_out pulse with code 1 each time; busy stays 0. Store to a never-loaded reg 3: code 2.
- Load and store start in the same cycle: LOAD entered, code 3. store_start_in during LOAD: code 3, load unaffected.
- rst low at element 3 of a 4x4 load: ready=0 at once. A subsequent store to that reg gives code 2.
- With TRANSPOSE_EN defined, load 2x2 as 1,2,3,4 and store with transpose=1: output 1,3,2,4; m_out=2, n_out=2; last on 4.
